cu_ctrl: RTL and testbench
==========================

CU_CTRL -- requirements
Module: cu_ctrl

Interface
REQ-001 Parameter PPG_WIDTH, default 10, SHALL set the width of the signed PPG sample.
REQ-002 Parameter CLK_FREQ_HZ, default 10_000_000, SHALL give the clock frequency in Hz.
REQ-003 Parameter SHOW_TIME_SEC, default 3, SHALL give the BPM display hold time in seconds.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-high reset; the historical name is kept but the signal is asserted at 1.
- check_btn  in  1  user "check" button, level input.
- en  in  1  global enable; 0 freezes the block.
- fifo_in_empty  in  1  input sample FIFO empty flag.
- fifo_in_rd  out  1  FIFO read strobe.
- fifo_in_dout  in  PPG_WIDTH  signed FIFO data, show-ahead (valid while !fifo_in_empty).
- db_en  out  1  one-cycle strobe: ppg_in holds a new sample.
- ppg_in  out  PPG_WIDTH  signed sample forwarded to the BPM detector.
- bpm_value  in  8  BPM result from the detector.
- bpm_valid  in  1  one-cycle strobe: bpm_value is valid.
- bpm_copied  out  1  one-cycle acknowledge that the BPM was latched.
- bpm_latest  out  8  last accepted BPM.
- bpm_ready_out  out  1  high while the BPM is being displayed.

Function
REQ-005 The FSM SHALL have three states: IDLE, MEASURE and SHOW.
REQ-006 A check event SHALL be a 0->1 edge of check_btn while en=1, detected against a registered copy of check_btn. A held button SHALL produce one event.
REQ-007 Transitions:
- IDLE: check event -> MEASURE.
- SHOW: check event -> MEASURE.
- MEASURE: bpm_valid=1 -> SHOW.
- SHOW: timer expiry -> IDLE.
REQ-008 On entry to MEASURE from SHOW, bpm_ready_out SHALL clear in the same clock edge, and bpm_latest SHALL hold its value.
REQ-009 fifo_in_rd SHALL be combinational and equal to (state==MEASURE && en && !fifo_in_empty).
REQ-010 On each cycle with fifo_in_rd=1, ppg_in SHALL register fifo_in_dout, and db_en SHALL be 1 in the following cycle only. Latency is 1 cycle.
REQ-011 In MEASURE, bpm_valid=1 SHALL cause these updates at that edge:
- bpm_latest <= bpm_value.
- bpm_copied = 1 for exactly the next cycle.
- bpm_ready_out <= 1.
- timer <= CLK_FREQ_HZ*SHOW_TIME_SEC-1.
REQ-012 The timer width SHALL be $clog2(CLK_FREQ_HZ*SHOW_TIME_SEC), minimum 1 bit. The timer SHALL decrement once per cycle in SHOW while en=1.
REQ-013 In SHOW, timer==0 SHALL move the FSM to IDLE and clear bpm_ready_out. bpm_ready_out is therefore high for exactly CLK_FREQ_HZ*SHOW_TIME_SEC cycles.
REQ-014 bpm_valid outside MEASURE SHALL be ignored: no latch and no bpm_copied.
REQ-015 Simultaneous events:
- Check event and timer expiry in the same cycle: the check event wins (-> MEASURE).
- bpm_valid and a check event in MEASURE: bpm_valid wins (-> SHOW).
REQ-016 With en=0, the block SHALL freeze:
- FSM, timer, ppg_in and bpm_latest hold.
- fifo_in_rd, db_en and bpm_copied are 0.
- Button edges are ignored, but the button register keeps sampling.
REQ-017 FIFO reads SHALL stop in the same cycle the FSM leaves MEASURE. A FIFO word is never read outside MEASURE.

Reset
REQ-018 With rst_n=1, reset SHALL act asynchronously and set:
- state IDLE, timer 0.
- ppg_in 0, bpm_latest 0.
- db_en, bpm_copied, bpm_ready_out 0.
- the button history register 0.
REQ-019 Reset asserted mid-MEASURE or mid-SHOW SHALL abort the operation, with no pending strobes after release.

Configuration
REQ-020 Macro CU_CTRL_BTN_SYNC_EN:
- Defined: check_btn SHALL pass through a 2-flop synchronizer (reset 0) before edge detection, so a check event takes effect 2 cycles later.
- Undefined: check_btn SHALL be edge-detected directly.
- All other behaviour is identical in both builds.

Verification (CLK_FREQ_HZ=100, SHOW_TIME_SEC=3, PPG_WIDTH=10)
REQ-021 Release reset, then pulse check_btn for 2 cycles -> FSM in MEASURE, exactly one check event, bpm_ready_out=0.
REQ-022 In MEASURE, drive 5 samples with fifo_in_empty=0 for one cycle each, e.g. -37 -> fifo_in_rd pulses 5 times, ppg_in=-37 and db_en=1 the next cycle, total db_en count 5.
REQ-023 In MEASURE, bpm_value=72 with bpm_valid for 1 cycle -> bpm_latest=72, bpm_copied is a single pulse, bpm_ready_out=1 for exactly 300 cycles, then IDLE.
REQ-024 In SHOW, press check, then return bpm_valid with 95 -> bpm_ready_out drops immediately, bpm_latest stays 72 until the valid, then becomes 95 and a new 300-cycle window starts.
REQ-025 Hold en=0 for 50 cycles mid-SHOW -> timer holds and the window extends by 50 cycles. bpm_valid or FIFO data while IDLE -> no bpm_copied, no fifo_in_rd.
REQ-026 Assert rst_n=1 mid-MEASURE with fifo_in_empty=0 -> fifo_in_rd=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/cu_ctrl.sv
// cu_ctrl: measurement control FSM. Forwards FIFO samples to the BPM detector,
// latches the BPM result and holds it on display. Optional macro: CU_CTRL_BTN_SYNC_EN.
module cu_ctrl #(
    parameter int PPG_WIDTH     = 10,
    parameter int CLK_FREQ_HZ   = 10_000_000,
    parameter int SHOW_TIME_SEC = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        check_btn,
    input  logic                        en,
    input  logic                        fifo_in_empty,
    output logic                        fifo_in_rd,
    input  logic signed [PPG_WIDTH-1:0] fifo_in_dout,
    output logic                        db_en,
    output logic signed [PPG_WIDTH-1:0] ppg_in,
    input  logic [7:0]                  bpm_value,
    input  logic                        bpm_valid,
    output logic                        bpm_copied,
    output logic [7:0]                  bpm_latest,
    output logic                        bpm_ready_out
);

    localparam int SHOW_CYCLES = CLK_FREQ_HZ * SHOW_TIME_SEC;
    localparam int TMR_W       = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StShow    = 2'd2
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_btn_hist;
    logic             w_btn;
    logic             w_check;

`ifdef CU_CTRL_BTN_SYNC_EN
    logic r_btn_s1;
    logic r_btn_s2;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_btn_s1 <= check_btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    assign w_btn = r_btn_s2;
`else
    assign w_btn = check_btn;
`endif

    // The history register samples even while frozen, so a press held across
    // an en=0 stretch does not fire when en returns.
    assign w_check    = en && w_btn && !r_btn_hist;
    assign fifo_in_rd = (r_state == StMeasure) && en && !fifo_in_empty;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_btn_hist    <= 1'b0;
            ppg_in        <= '0;
            db_en         <= 1'b0;
            bpm_copied    <= 1'b0;
            bpm_latest    <= '0;
            bpm_ready_out <= 1'b0;
        end else begin
            r_btn_hist <= w_btn;
            db_en      <= fifo_in_rd;
            bpm_copied <= 1'b0;
            if (fifo_in_rd) begin
                ppg_in <= fifo_in_dout;
            end
            if (en) begin
                case (r_state)
                    StIdle: begin
                        if (w_check) begin
                            r_state <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        // A result beats a simultaneous press.
                        if (bpm_valid) begin
                            r_state       <= StShow;
                            bpm_latest    <= bpm_value;
                            bpm_copied    <= 1'b1;
                            bpm_ready_out <= 1'b1;
                            r_timer       <= TMR_LOAD;
                        end
                    end
                    StShow: begin
                        // A press beats a simultaneous expiry.
                        if (w_check) begin
                            r_state       <= StMeasure;
                            bpm_ready_out <= 1'b0;
                        end else if (r_timer == '0) begin
                            r_state       <= StIdle;
                            bpm_ready_out <= 1'b0;
                        end else begin
                            r_timer <= r_timer - TMR_W'(1);
                        end
                    end
                    default: begin
                        r_state       <= StIdle;
                        bpm_ready_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cu_ctrl.sv
// tb_cu_ctrl: table-driven directed vectors, hand sequences for display windows
// and reset, then randomized stimulus against a behavioural model.
module tb_cu_ctrl;

    localparam int N = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              check_btn;
    logic              en;
    logic              fifo_in_empty;
    logic              fifo_in_rd;
    logic signed [9:0] fifo_in_dout;
    logic              db_en;
    logic signed [9:0] ppg_in;
    logic [7:0]        bpm_value;
    logic              bpm_valid;
    logic              bpm_copied;
    logic [7:0]        bpm_latest;
    logic              bpm_ready_out;

    always #5 clk = ~clk;

    cu_ctrl #(
        .PPG_WIDTH    (10),
        .CLK_FREQ_HZ  (100),
        .SHOW_TIME_SEC(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .check_btn    (check_btn),
        .en           (en),
        .fifo_in_empty(fifo_in_empty),
        .fifo_in_rd   (fifo_in_rd),
        .fifo_in_dout (fifo_in_dout),
        .db_en        (db_en),
        .ppg_in       (ppg_in),
        .bpm_value    (bpm_value),
        .bpm_valid    (bpm_valid),
        .bpm_copied   (bpm_copied),
        .bpm_latest   (bpm_latest),
        .bpm_ready_out(bpm_ready_out)
    );

    typedef struct {
        logic              btn;
        logic              en;
        logic              empty;
        logic signed [9:0] dout;
        logic              valid;
        logic [7:0]        value;
        logic              x_rd;
        logic              x_db;
        logic signed [9:0] x_ppg;
        logic              x_cp;
        logic [7:0]        x_latest;
        logic              x_ready;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int rd_seen = 0;
    int db_seen = 0;

    // Model: mode 0 idle, 1 measuring, 2 showing; m_left = display cycles still owed.
    int                m_mode;
    int                m_left;
    logic              m_prev;
    logic signed [9:0] m_ppg;
    logic              m_db;
    logic              m_cp;
    logic [7:0]        m_latest;

    function automatic vec_t mk(input int b, input int e, input int em, input int d,
                                input int v, input int val, input int xr, input int xd,
                                input int xp, input int xc, input int xl, input int xy);
        vec_t r;
        r.btn = 1'(b);      r.en = 1'(e);       r.empty = 1'(em);
        r.dout = 10'(d);    r.valid = 1'(v);    r.value = 8'(val);
        r.x_rd = 1'(xr);    r.x_db = 1'(xd);    r.x_ppg = 10'(xp);
        r.x_cp = 1'(xc);    r.x_latest = 8'(xl); r.x_ready = 1'(xy);
        return r;
    endfunction

    function automatic vec_t in_only(input int b, input int e, input int em, input int d,
                                     input int v, input int val);
        return mk(b, e, em, d, v, val, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, $signed(act), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_prev = 1'b0; m_ppg = '0;
        m_db = 1'b0; m_cp = 1'b0; m_latest = '0;
    endtask

    function automatic logic m_rd();
        return (m_mode == 1) && en && !fifo_in_empty;
    endfunction

    task automatic model_step(input vec_t v);
        logic rd;
        logic ev;
        rd = (m_mode == 1) && v.en && !v.empty;
        ev = v.en && v.btn && !m_prev;
        m_prev = v.btn;
        m_db = rd;
        if (rd) m_ppg = v.dout;
        m_cp = 1'b0;
        if (v.en) begin
            if (m_mode == 0) begin
                if (ev) m_mode = 1;
            end else if (m_mode == 1) begin
                if (v.valid) begin
                    m_latest = v.value; m_cp = 1'b1; m_mode = 2; m_left = N;
                end
            end else if (ev) begin
                m_mode = 1;
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
    endtask

    // Starts just after a rising edge; ends 1 time unit after the next one.
    task automatic run_cycle(input vec_t v, input bit use_tbl);
        check_btn = v.btn; en = v.en; fifo_in_empty = v.empty;
        fifo_in_dout = v.dout; bpm_valid = v.valid; bpm_value = v.value;
        @(negedge clk);
        if (fifo_in_rd) rd_seen++;
        chk("fifo_in_rd", 32'(fifo_in_rd), use_tbl ? 32'(v.x_rd) : 32'(m_rd()));
        @(posedge clk);
        model_step(v);
        #1;
        if (db_en) db_seen++;
        if (use_tbl) begin
            chk("db_en", 32'(db_en), 32'(v.x_db));
            chk("ppg_in", 32'(ppg_in), 32'(v.x_ppg));
            chk("bpm_copied", 32'(bpm_copied), 32'(v.x_cp));
            chk("bpm_latest", 32'(bpm_latest), 32'(v.x_latest));
            chk("bpm_ready_out", 32'(bpm_ready_out), 32'(v.x_ready));
        end else begin
            chk("db_en", 32'(db_en), 32'(m_db));
            chk("ppg_in", 32'(ppg_in), 32'(m_ppg));
            chk("bpm_copied", 32'(bpm_copied), 32'(m_cp));
            chk("bpm_latest", 32'(bpm_latest), 32'(m_latest));
            chk("bpm_ready_out", 32'(bpm_ready_out), 32'(m_mode == 2));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd"}, 32'(fifo_in_rd), 0);
        chk({tag, "_db"}, 32'(db_en), 0);
        chk({tag, "_ppg"}, 32'(ppg_in), 0);
        chk({tag, "_cp"}, 32'(bpm_copied), 0);
        chk({tag, "_latest"}, 32'(bpm_latest), 0);
        chk({tag, "_ready"}, 32'(bpm_ready_out), 0);
    endtask

    // Run with idle inputs until the display drops; returns ready-high samples seen.
    task automatic drain(output int cnt, input int cp_expect, input string nm);
        int cp_cnt;
        cnt = 0;
        cp_cnt = 0;
        for (int i = 0; i < 500 && bpm_ready_out; i++) begin
            run_cycle(in_only(0, 1, 1, 0, 0, 0), 1'b0);
            if (bpm_ready_out) cnt++;
            if (bpm_copied) cp_cnt++;
        end
        chk({nm, "_timeout"}, 32'(bpm_ready_out), 0);
        chk({nm, "_extra_copy"}, 32'(cp_cnt), 32'(cp_expect));
    endtask

    vec_t tbl[13];
    vec_t idle_v;
    int   cnt;
    int   win;
    logic r_b;

    initial begin
        idle_v = in_only(0, 1, 1, 0, 0, 0);
        //          btn en emp dout val value | rd db  ppg  cp lat rdy
        tbl[0]  = mk(1, 1, 1,    0, 0,  0,     0, 0,    0, 0,  0, 0);
        tbl[1]  = mk(1, 1, 1,    0, 0,  0,     0, 0,    0, 0,  0, 0);
        tbl[2]  = mk(0, 1, 0,  -37, 0,  0,     1, 1,  -37, 0,  0, 0);
        tbl[3]  = mk(0, 1, 0,  100, 0,  0,     1, 1,  100, 0,  0, 0);
        tbl[4]  = mk(0, 1, 1,    5, 0,  0,     0, 0,  100, 0,  0, 0);
        tbl[5]  = mk(1, 1, 0, -512, 0,  0,     1, 1, -512, 0,  0, 0);
        tbl[6]  = mk(0, 0, 0,    7, 1,  9,     0, 0, -512, 0,  0, 0);
        tbl[7]  = mk(0, 1, 0,    3, 1, 72,     1, 1,    3, 1, 72, 1);
        tbl[8]  = mk(0, 1, 0,   11, 1, 50,     0, 0,    3, 0, 72, 1);
        tbl[9]  = mk(1, 1, 1,    0, 0,  0,     0, 0,    3, 0, 72, 0);
        tbl[10] = mk(0, 1, 0,   -1, 0,  0,     1, 1,   -1, 0, 72, 0);
        tbl[11] = mk(1, 1, 1,    0, 1, 95,     0, 0,   -1, 1, 95, 1);
        tbl[12] = mk(0, 1, 0,   44, 0,  0,     0, 0,   -1, 0, 95, 1);

        rst_n = 1'b1; check_btn = 1'b0; en = 1'b1; fifo_in_empty = 1'b1;
        fifo_in_dout = '0; bpm_valid = 1'b0; bpm_value = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        model_step(idle_v);
        #1;

        // Directed table: press, samples, freeze, latch, re-check, valid-vs-check.
        rd_seen = 0;
        db_seen = 0;
        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);
        chk("tbl_rd_count", 32'(rd_seen), 5);
        chk("tbl_db_count", 32'(db_seen), 5);
        drain(cnt, 0, "tbl_drain");
        chk("tbl_window", 32'(cnt + 2), N);

        // Fresh window: two-cycle press, then a single valid with 72.
        run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        chk("press_no_ready", 32'(bpm_ready_out), 0);
        run_cycle(in_only(0, 1, 1, 0, 1, 72), 1'b0);
        chk("copied_72", 32'(bpm_copied), 1);
        drain(cnt, 0, "win72");
        chk("window_300", 32'(cnt + 1), N);

        // Window stretched by a 50-cycle freeze.
        run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        run_cycle(in_only(0, 1, 1, 0, 1, 80), 1'b0);
        win = 1;
        for (int i = 0; i < 100; i++) begin
            run_cycle(idle_v, 1'b0);
            if (bpm_ready_out) win++;
        end
        for (int i = 0; i < 50; i++) begin
            run_cycle(in_only(i % 7 == 0 ? 1 : 0, 0, 0, i, 1, i), 1'b0);
            if (bpm_ready_out) win++;
        end
        drain(cnt, 0, "win_freeze");
        chk("window_350", 32'(win + cnt), N + 50);

        // Idle ignores bpm_valid and FIFO data.
        rd_seen = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle(in_only(0, 1, 0, 13 * i - 100, 1, 200 - i), 1'b0);
            if (bpm_copied) cnt++;
        end
        chk("idle_no_copy", 32'(cnt), 0);
        chk("idle_no_rd", 32'(rd_seen), 0);

        // Randomized traffic against the model.
        r_b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) r_b = ~r_b;
            run_cycle(in_only(int'(r_b), int'($urandom_range(0, 9) != 0),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                              int'($urandom_range(0, 29) == 0), int'($urandom_range(0, 255))),
                      1'b0);
        end

        // Reset mid-MEASURE while the FIFO is being read.
        run_cycle(in_only(0, 1, 1, 0, 0, 0), 1'b0);
        run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        if (m_mode == 0) run_cycle(in_only(0, 1, 1, 0, 0, 0), 1'b0);
        if (m_mode == 0) run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        if (m_mode == 2) begin
            run_cycle(in_only(0, 1, 1, 0, 0, 0), 1'b0);
            run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        end
        run_cycle(in_only(0, 1, 0, 77, 1, 33), 1'b0);
        run_cycle(in_only(1, 1, 1, 0, 0, 0), 1'b0);
        check_btn = 1'b0; fifo_in_empty = 1'b0; fifo_in_dout = 10'sd21; bpm_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_rd", 32'(fifo_in_rd), 1);
        #1 rst_n = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        model_reset();
        fifo_in_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        model_step(idle_v);
        #1;
        for (int i = 0; i < 5; i++) run_cycle(idle_v, 1'b0);
        chk_reset_outputs("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
